user_reg_bus_arbiter: RTL and testbench
=======================================

// Module: user_reg_bus_arbiter
// PURPOSE
//  Round-robin arbiter giving two requesters (m0: host AXI-Lite bridge, m1: local
//  init/config sequencer) shared access to one Bus2IP/IP2Bus user register slave.
//  Issues a single-cycle CS per transaction and waits for the slave's RdAck/WrAck.
//  Checks each request's address range, applies a no-ack timeout and counts timeouts.
// PARAMETERS
//  C_S_AXI_BASEADDR  32'h0000_0000  lowest legal address, inclusive
//  C_S_AXI_HIGHADDR  32'h0000_FFFF  highest legal address, inclusive
//  TIMEOUT_CYCLES    16             WAIT_ACK cycles before an error response (>=2)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   synchronous, active-low reset
//  mN_req         in   1   N=0,1: request; held, payload stable, until mN_ack
//  mN_addr        in   32  request address
//  mN_rnw         in   1   1=read, 0=write
//  mN_wdata       in   32  write data
//  mN_ack         out  1   one-cycle completion pulse
//  mN_rdata       out  32  read data, valid with mN_ack; 0 on writes/errors
//  mN_err         out  1   error flag, valid with mN_ack
//  Bus2IP_Addr    out  32  slave address
//  Bus2IP_RNW     out  1   slave read/write select
//  Bus2IP_CS      out  1   slave select, exactly one cycle per transaction
//  Bus2IP_Data    out  32  slave write data
//  IP2Bus_Data    in   32  slave read data
//  IP2Bus_WrAck   in   1   slave write ack
//  IP2Bus_RdAck   in   1   slave read ack
//  IP2Bus_Error   in   1   slave error
//  busy           out  1   high whenever FSM != IDLE
//  timeout_count  out  16  saturating count of timed-out transactions
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr_last=1 (m0 wins first tie); timeout counter=0.
//  FSM states: IDLE, ISSUE, WAIT_ACK, RESP. All outputs registered.
//  IDLE: if any req, grant it; on tie grant the master != rr_last. Latch grant plus
//   addr/rnw/wdata. In range (BASE<=addr<=HIGH) -> ISSUE. Out of range -> RESP with
//   err=1, rdata=0; slave not touched. No req -> stay IDLE.
//  ISSUE: CS=1 for this one cycle, driving latched addr/rnw/data -> WAIT_ACK.
//  WAIT_ACK: CS=0, Addr/RNW/Data held. Ack = RdAck|WrAck, either type accepted.
//   Ack -> RESP capturing rdata=(rnw ? IP2Bus_Data : 0), err=IP2Bus_Error.
//   No ack for TIMEOUT_CYCLES cycles -> RESP with err=1, rdata=0; timeout_count+1,
//   saturating at 16'hFFFF. Ack on the expiry cycle counts as ack, not timeout.
//  RESP: granted mN_ack=1 for one cycle with rdata/err; rr_last<=grant -> IDLE.
//  Latency, in-range access with the slave acking 1 cycle after CS: req seen in
//   IDLE at cycle T; CS at T+1; ack at T+2; mN_ack at T+3; next IDLE at T+4.
//   Out-of-range: mN_ack at T+1.
//  Back-to-back: a master may keep req high after its ack to start a new
//   transaction; it is re-sampled in IDLE under round-robin, so a waiting peer wins.
//  Stray acks in IDLE/ISSUE/RESP are ignored.
//  req drop before ack is a protocol violation; the transaction still completes.
//  Reset mid-transaction: immediate return to IDLE, CS=0, no mN_ack produced.
//  Bus2IP_Addr/RNW/Data: 0 in IDLE, otherwise the latched request.
// TESTING
//  1 m0 write 0x10=0x12345678 alone -> 1 CS pulse; m0_ack at T+3, err=0; a m0 read
//    of 0x10 then returns 0x12345678.
//  2 m0,m1 req same cycle after reset -> m0 served first, then m1. Both held
//    continuously -> grants alternate m0,m1,m0,m1.
//  3 Read 0x0001_0000 with HIGH=0xFFFF -> m_ack at T+1, err=1, rdata=0, CS never high.
//  4 Slave never acks, TIMEOUT_CYCLES=16 -> ack 16 cycles into WAIT_ACK, err=1,
//    timeout_count=1. Preload 0xFFFF -> stays 0xFFFF.
//  5 rst_n low during WAIT_ACK -> next cycle busy=0, CS=0, no ack. Restart ok, m0 first.
//  6 Read 0x04 with slave IP2Bus_Error=1 on ack -> rdata=IP2Bus_Data, err=1.

Source files
------------

// File: rtl/user_reg_bus_arbiter_if.sv
// Two-requester register access channel plus the shared Bus2IP/IP2Bus slave bus.
// The arbiter takes the master modport; requesters and the register slave sit on the slave side.
interface user_reg_bus_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_rnw;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_rnw;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic [31:0] Bus2IP_Addr;
    logic        Bus2IP_RNW;
    logic        Bus2IP_CS;
    logic [31:0] Bus2IP_Data;
    logic [31:0] IP2Bus_Data;
    logic        IP2Bus_WrAck;
    logic        IP2Bus_RdAck;
    logic        IP2Bus_Error;

    modport master (
        input  m0_req, m0_addr, m0_rnw, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_rnw, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output Bus2IP_Addr, Bus2IP_RNW, Bus2IP_CS, Bus2IP_Data,
        input  IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error
    );

    modport slave (
        output m0_req, m0_addr, m0_rnw, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_rnw, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  Bus2IP_Addr, Bus2IP_RNW, Bus2IP_CS, Bus2IP_Data,
        output IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error
    );
endinterface

// File: rtl/user_reg_bus_arbiter.sv
// Round-robin arbiter sharing one Bus2IP/IP2Bus register slave between two requesters,
// with address range checking, a no-ack timeout and a saturating timeout counter.
module user_reg_bus_arbiter #(
    parameter logic [31:0] C_S_AXI_BASEADDR = 32'h0000_0000,
    parameter logic [31:0] C_S_AXI_HIGHADDR = 32'h0000_FFFF,
    parameter int          TIMEOUT_CYCLES   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    user_reg_bus_arbiter_if.master        bus,
    output logic                          busy,
    output logic [15:0]                   timeout_count
);
    localparam int          CNT_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [31:0] RANGE_SPAN = C_S_AXI_HIGHADDR - C_S_AXI_BASEADDR;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_grant;
    logic               r_rr_last;
    logic [31:0]        r_addr;
    logic               r_rnw;
    logic [31:0]        r_wdata;
    logic               r_cs;
    logic               r_busy;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [15:0]        r_timeout_count;
    logic [1:0]         r_ack;
    logic [1:0]         r_err;
    logic [1:0][31:0]   r_rdata;

    logic               w_any_req;
    logic               w_grant;
    logic [31:0]        w_addr;
    logic               w_rnw;
    logic [31:0]        w_wdata;
    logic               w_in_range;
    logic               w_slave_ack;

    always_comb begin
        w_any_req = bus.m0_req | bus.m1_req;
        // On a tie the master that was not served last wins; otherwise whoever is asking.
        if (bus.m0_req && bus.m1_req) begin
            w_grant = ~r_rr_last;
        end else begin
            w_grant = bus.m1_req;
        end
        w_addr      = w_grant ? bus.m1_addr  : bus.m0_addr;
        w_rnw       = w_grant ? bus.m1_rnw   : bus.m0_rnw;
        w_wdata     = w_grant ? bus.m1_wdata : bus.m0_wdata;
        // Offset compare handles any base without a constant-true lower-bound test.
        w_in_range  = (w_addr - C_S_AXI_BASEADDR) <= RANGE_SPAN;
        w_slave_ack = bus.IP2Bus_RdAck | bus.IP2Bus_WrAck;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_grant         <= 1'b0;
            r_rr_last       <= 1'b1;
            r_addr          <= '0;
            r_rnw           <= 1'b0;
            r_wdata         <= '0;
            r_cs            <= 1'b0;
            r_busy          <= 1'b0;
            r_wait_cnt      <= '0;
            r_timeout_count <= '0;
            r_ack           <= '0;
            r_err           <= '0;
            r_rdata         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_grant;
                        r_addr  <= w_addr;
                        r_rnw   <= w_rnw;
                        r_wdata <= w_wdata;
                        r_busy  <= 1'b1;
                        if (w_in_range) begin
                            r_state <= S_ISSUE;
                            r_cs    <= 1'b1;
                        end else begin
                            r_state          <= S_RESP;
                            r_ack[w_grant]   <= 1'b1;
                            r_err[w_grant]   <= 1'b1;
                            r_rdata[w_grant] <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cs       <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (w_slave_ack) begin
                        r_state          <= S_RESP;
                        r_ack[r_grant]   <= 1'b1;
                        r_err[r_grant]   <= bus.IP2Bus_Error;
                        r_rdata[r_grant] <= r_rnw ? bus.IP2Bus_Data : 32'h0;
                    end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state          <= S_RESP;
                        r_ack[r_grant]   <= 1'b1;
                        r_err[r_grant]   <= 1'b1;
                        r_rdata[r_grant] <= '0;
                        if (r_timeout_count != 16'hFFFF) begin
                            r_timeout_count <= r_timeout_count + 16'd1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_rr_last <= r_grant;
                    r_busy    <= 1'b0;
                    r_ack     <= '0;
                    r_err     <= '0;
                    r_rdata   <= '0;
                    r_addr    <= '0;
                    r_rnw     <= 1'b0;
                    r_wdata   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m0_ack      = r_ack[0];
    assign bus.m0_err      = r_err[0];
    assign bus.m0_rdata    = r_rdata[0];
    assign bus.m1_ack      = r_ack[1];
    assign bus.m1_err      = r_err[1];
    assign bus.m1_rdata    = r_rdata[1];
    assign bus.Bus2IP_Addr = r_addr;
    assign bus.Bus2IP_RNW  = r_rnw;
    assign bus.Bus2IP_CS   = r_cs;
    assign bus.Bus2IP_Data = r_wdata;
    assign busy            = r_busy;
    assign timeout_count   = r_timeout_count;
endmodule

// File: tb/tb_user_reg_bus_arbiter.sv
// Directed bench for user_reg_bus_arbiter: a vector table of single transactions against a
// small register-slave model, plus hand sequences for arbitration, saturation and reset.
module tb_user_reg_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] timeout_count;

    always #5 clk = ~clk;

    user_reg_bus_arbiter_if bus_if ();

    user_reg_bus_arbiter #(
        .C_S_AXI_BASEADDR (32'h0000_0000),
        .C_S_AXI_HIGHADDR (32'h0000_FFFF),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus_if),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register slave: acks slv_delay cycles after CS (0 = never acks).
    logic [31:0] mem [256];
    int          slv_delay = 1;
    logic        slv_err   = 1'b0;

    initial begin : slave_model
        logic [7:0] idx;
        logic       rnw_l;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_if.Bus2IP_CS === 1'b1) begin
                idx   = bus_if.Bus2IP_Addr[9:2];
                rnw_l = bus_if.Bus2IP_RNW;
                if (!rnw_l) mem[idx] = bus_if.Bus2IP_Data;
                if (slv_delay != 0) begin
                    repeat (slv_delay) @(posedge clk);
                    #1;
                    bus_if.IP2Bus_RdAck = rnw_l;
                    bus_if.IP2Bus_WrAck = !rnw_l;
                    bus_if.IP2Bus_Data  = rnw_l ? mem[idx] : 32'h0;
                    bus_if.IP2Bus_Error = slv_err;
                    @(posedge clk);
                    #1;
                    bus_if.IP2Bus_RdAck = 1'b0;
                    bus_if.IP2Bus_WrAck = 1'b0;
                    bus_if.IP2Bus_Data  = 32'h0;
                    bus_if.IP2Bus_Error = 1'b0;
                end
            end
        end
    end

    task automatic run_txn(input int m, input logic [31:0] a, input logic rnw, input logic [31:0] wd,
                           output int lat, output int cs_cnt, output int busy_cnt, output int other,
                           output logic [31:0] rd, output logic er);
        lat = -1; cs_cnt = 0; busy_cnt = 0; other = 0; rd = 32'h0; er = 1'b0;
        @(posedge clk);
        #1;
        if (m == 0) begin
            bus_if.m0_req = 1'b1; bus_if.m0_addr = a; bus_if.m0_rnw = rnw; bus_if.m0_wdata = wd;
        end else begin
            bus_if.m1_req = 1'b1; bus_if.m1_addr = a; bus_if.m1_rnw = rnw; bus_if.m1_wdata = wd;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus_if.Bus2IP_CS === 1'b1) cs_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (((m == 0) ? bus_if.m1_ack : bus_if.m0_ack) === 1'b1) other++;
            if (((m == 0) ? bus_if.m0_ack : bus_if.m1_ack) === 1'b1) begin
                lat = n;
                rd  = (m == 0) ? bus_if.m0_rdata : bus_if.m1_rdata;
                er  = (m == 0) ? bus_if.m0_err : bus_if.m1_err;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus_if.m0_req = 1'b0;
        bus_if.m1_req = 1'b0;
    endtask

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic        rnw;
        logic [31:0] wdata;
        int          dly;
        logic        serr;
        int          exp_lat;
        int          exp_cs;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [15:0] exp_to;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin : main
        int          lat, cs_cnt, busy_cnt, other, nacks;
        logic [31:0] rd;
        logic        er;
        int          ack_m [4];
        int          ack_n [4];

        //             m  addr          rnw   wdata         dly serr  lat cs err   rdata          to
        vecs[0]  = '{0, 32'h0000_0010, 1'b0, 32'h1234_5678, 1, 1'b0, 3,  1, 1'b0, 32'h0000_0000, 16'd0};
        vecs[1]  = '{0, 32'h0000_0010, 1'b1, 32'h0000_0000, 1, 1'b0, 3,  1, 1'b0, 32'h1234_5678, 16'd0};
        vecs[2]  = '{1, 32'h0000_0020, 1'b0, 32'hCAFE_F00D, 1, 1'b0, 3,  1, 1'b0, 32'h0000_0000, 16'd0};
        vecs[3]  = '{1, 32'h0000_0020, 1'b1, 32'h0000_0000, 1, 1'b0, 3,  1, 1'b0, 32'hCAFE_F00D, 16'd0};
        vecs[4]  = '{1, 32'h0000_0010, 1'b1, 32'h0000_0000, 1, 1'b0, 3,  1, 1'b0, 32'h1234_5678, 16'd0};
        vecs[5]  = '{0, 32'h0001_0000, 1'b1, 32'h0000_0000, 1, 1'b0, 1,  0, 1'b1, 32'h0000_0000, 16'd0};
        vecs[6]  = '{1, 32'h0000_FFFF, 1'b0, 32'hA5A5_A5A5, 1, 1'b0, 3,  1, 1'b0, 32'h0000_0000, 16'd0};
        vecs[7]  = '{0, 32'h0000_FFFC, 1'b1, 32'h0000_0000, 1, 1'b0, 3,  1, 1'b0, 32'hA5A5_A5A5, 16'd0};
        vecs[8]  = '{1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1, 1'b0, 1,  0, 1'b1, 32'h0000_0000, 16'd0};
        vecs[9]  = '{0, 32'h0000_0004, 1'b0, 32'h0BAD_BEEF, 1, 1'b0, 3,  1, 1'b0, 32'h0000_0000, 16'd0};
        vecs[10] = '{0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1, 1'b1, 3,  1, 1'b1, 32'h0BAD_BEEF, 16'd0};
        vecs[11] = '{1, 32'h0000_0008, 1'b0, 32'h0000_0001, 1, 1'b1, 3,  1, 1'b1, 32'h0000_0000, 16'd0};
        vecs[12] = '{0, 32'h0000_0020, 1'b1, 32'h0000_0000, 16, 1'b0, 18, 1, 1'b0, 32'hCAFE_F00D, 16'd0};
        vecs[13] = '{1, 32'h0000_0010, 1'b1, 32'h0000_0000, 0, 1'b0, 18, 1, 1'b1, 32'h0000_0000, 16'd1};
        vecs[14] = '{0, 32'h0000_0024, 1'b0, 32'h0000_0077, 17, 1'b0, 18, 1, 1'b1, 32'h0000_0000, 16'd2};
        vecs[15] = '{0, 32'h0000_0024, 1'b1, 32'h0000_0000, 1, 1'b0, 3,  1, 1'b0, 32'h0000_0077, 16'd2};

        rst_n = 1'b0;
        bus_if.m0_req = 1'b0; bus_if.m0_addr = '0; bus_if.m0_rnw = 1'b0; bus_if.m0_wdata = '0;
        bus_if.m1_req = 1'b0; bus_if.m1_addr = '0; bus_if.m1_rnw = 1'b0; bus_if.m1_wdata = '0;
        bus_if.IP2Bus_Data = '0; bus_if.IP2Bus_WrAck = 1'b0;
        bus_if.IP2Bus_RdAck = 1'b0; bus_if.IP2Bus_Error = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_cs", 32'(bus_if.Bus2IP_CS), 32'h0);
        chk("reset_m0_ack", 32'(bus_if.m0_ack), 32'h0);
        chk("reset_m1_ack", 32'(bus_if.m1_ack), 32'h0);
        chk("reset_addr", bus_if.Bus2IP_Addr, 32'h0);
        chk("reset_tocount", 32'(timeout_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Simultaneous requests right after reset, both held: m0,m1,m0,m1 every 4 cycles.
        @(posedge clk);
        #1;
        bus_if.m0_req = 1'b1; bus_if.m0_addr = 32'h30; bus_if.m0_rnw = 1'b0; bus_if.m0_wdata = 32'h300;
        bus_if.m1_req = 1'b1; bus_if.m1_addr = 32'h34; bus_if.m1_rnw = 1'b0; bus_if.m1_wdata = 32'h340;
        nacks = 0;
        for (int n = 0; n < 40 && nacks < 4; n++) begin
            @(negedge clk);
            if (bus_if.m0_ack === 1'b1) begin ack_m[nacks] = 0; ack_n[nacks] = n; nacks++; end
            else if (bus_if.m1_ack === 1'b1) begin ack_m[nacks] = 1; ack_n[nacks] = n; nacks++; end
        end
        @(posedge clk);
        #1;
        bus_if.m0_req = 1'b0;
        bus_if.m1_req = 1'b0;
        chk("tie_ack_count", 32'(nacks), 32'd4);
        for (int i = 0; i < nacks; i++) begin
            $display("[TB] tie grant %0d -> m%0d at cycle %0d", i, ack_m[i], ack_n[i]);
            chk($sformatf("tie_master_%0d", i), 32'(ack_m[i]), 32'(i % 2));
            chk($sformatf("tie_cycle_%0d", i), 32'(ack_n[i]), 32'(3 + 4 * i));
        end

        for (int i = 0; i < NV; i++) begin
            slv_delay = vecs[i].dly;
            slv_err   = vecs[i].serr;
            run_txn(vecs[i].m, vecs[i].addr, vecs[i].rnw, vecs[i].wdata,
                    lat, cs_cnt, busy_cnt, other, rd, er);
            $display("[TB] vec %0d m%0d %s addr=%h lat=%0d cs=%0d err=%b rdata=%h tocnt=%0d",
                     i, vecs[i].m, vecs[i].rnw ? "RD" : "WR", vecs[i].addr, lat, cs_cnt, er, rd,
                     timeout_count);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_cs_pulses", i), 32'(cs_cnt), 32'(vecs[i].exp_cs));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_other_ack", i), 32'(other), 32'h0);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_tocount", i), 32'(timeout_count), 32'(vecs[i].exp_to));
        end
        slv_delay = 1;
        slv_err   = 1'b0;

        // Saturation: preload the counter at its ceiling, then time out once more.
        @(negedge clk);
        force dut.r_timeout_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_timeout_count;
        slv_delay = 0;
        run_txn(0, 32'h40, 1'b1, 32'h0, lat, cs_cnt, busy_cnt, other, rd, er);
        $display("[TB] saturate m0 RD addr=00000040 lat=%0d err=%b tocnt=%h", lat, er, timeout_count);
        chk("sat_latency", 32'(lat), 32'd18);
        chk("sat_err", 32'(er), 32'h1);
        chk("sat_tocount", 32'(timeout_count), 32'h0000_FFFF);
        slv_delay = 1;

        // Stray ack while idle must not produce a completion.
        @(posedge clk);
        #1;
        bus_if.IP2Bus_RdAck = 1'b1;
        bus_if.IP2Bus_Data  = 32'hDEAD_0001;
        @(posedge clk);
        #1;
        bus_if.IP2Bus_RdAck = 1'b0;
        bus_if.IP2Bus_Data  = 32'h0;
        other = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (bus_if.m0_ack === 1'b1 || bus_if.m1_ack === 1'b1 || busy === 1'b1) other++;
        end
        $display("[TB] stray idle ack -> activity=%0d", other);
        chk("stray_ack_activity", 32'(other), 32'h0);

        // Reset while waiting for an ack that never comes.
        slv_delay = 0;
        @(posedge clk);
        #1;
        bus_if.m0_req = 1'b1; bus_if.m0_addr = 32'h50; bus_if.m0_rnw = 1'b1; bus_if.m0_wdata = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_in_wait_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        bus_if.m0_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_cs", 32'(bus_if.Bus2IP_CS), 32'h0);
        chk("midrst_ack", 32'(bus_if.m0_ack), 32'h0);
        chk("midrst_tocount", 32'(timeout_count), 32'h0);
        other = 0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            if (bus_if.m0_ack === 1'b1 || bus_if.m1_ack === 1'b1) other++;
        end
        chk("midrst_no_ack", 32'(other), 32'h0);
        $display("[TB] reset during WAIT_ACK -> busy=%b cs=%b", busy, bus_if.Bus2IP_CS);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slv_delay = 1;

        // Restart: a tie must again go to m0 first.
        @(posedge clk);
        #1;
        bus_if.m0_req = 1'b1; bus_if.m0_addr = 32'h10; bus_if.m0_rnw = 1'b1;
        bus_if.m1_req = 1'b1; bus_if.m1_addr = 32'h20; bus_if.m1_rnw = 1'b1;
        nacks = 0;
        lat   = -1;
        ack_m[0] = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus_if.m0_ack === 1'b1 || bus_if.m1_ack === 1'b1) begin
                ack_m[0] = (bus_if.m0_ack === 1'b1) ? 0 : 1;
                lat = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus_if.m0_req = 1'b0;
        bus_if.m1_req = 1'b0;
        $display("[TB] restart tie -> m%0d at cycle %0d", ack_m[0], lat);
        chk("restart_first_master", 32'(ack_m[0]), 32'h0);
        chk("restart_latency", 32'(lat), 32'd3);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
